// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared segment patterns, seg7_t type and BCD nibble helper
package bcd_pkg;

  // Segment vector ordered g..a; a lit segment is driven low.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b1000000;
  localparam seg7_t SEG_1     = 7'b1111001;
  localparam seg7_t SEG_2     = 7'b0100100;
  localparam seg7_t SEG_3     = 7'b0110000;
  localparam seg7_t SEG_4     = 7'b0011001;
  localparam seg7_t SEG_5     = 7'b0010010;
  localparam seg7_t SEG_6     = 7'b0000010;
  localparam seg7_t SEG_7     = 7'b1111000;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0010000;
  localparam seg7_t SEG_BLANK = 7'b1111111;

  function automatic logic bcd_valid(input logic [3:0] nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_seg7.sv
// rtl/bcd_seg7.sv - combinational BCD nibble to active-low 7-segment decoder
module bcd_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_hex.sv
// rtl/bcd_counter_hex.sv - prescaled BCD up/down counter with validated load and 7-seg outputs
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module bcd_counter_hex
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  clr_err,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  carry,
  output logic                  err,
  output logic [DIGITS-1:0]     err_digit
);

  localparam int                PCNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0]   pcnt_q,      pcnt_d;
  logic [4*DIGITS-1:0] bcd_q,       bcd_d;
  logic                carry_q,     carry_d;
  logic                err_q,       err_d;
  logic [DIGITS-1:0]   err_digit_q, err_digit_d;

  logic                tick;
  logic [DIGITS-1:0]   load_bad;
  logic                load_ok;
  logic                load_rej;
  logic [4*DIGITS-1:0] step_val;
  logic                step_wrap;
  logic                ripple;
  logic [DIGITS-1:0]   blank_mask;

  assign tick = (pcnt_q == PCNT_LAST);

  always_comb begin
    load_bad = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_bad[i] = !bcd_valid(load_val[4*i +: 4]);
    end
  end

  assign load_ok  = load && (load_bad == '0);
  assign load_rej = load && (load_bad != '0);

  // Ripple one step through the digits; a carry/borrow surviving past the top digit is a wrap.
  always_comb begin
    step_val = bcd_q;
    ripple   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        if (up) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            ripple             = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            ripple             = 1'b0;
          end
        end
      end
    end
    step_wrap = ripple;
  end

  always_comb begin
    pcnt_d      = tick ? '0 : pcnt_q + PCNT_W'(1);
    bcd_d       = bcd_q;
    carry_d     = 1'b0;
    err_d       = err_q;
    err_digit_d = err_digit_q;

    // Any load request, accepted or not, swallows the tick of that cycle.
    if (load_ok) begin
      bcd_d  = load_val;
      pcnt_d = '0;
    end else if (!load && tick && en) begin
      bcd_d   = step_val;
      carry_d = step_wrap;
    end

    if (load_rej) begin
      err_d       = 1'b1;
      err_digit_d = load_bad;
    end else if (clr_err) begin
      err_d       = 1'b0;
      err_digit_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      pcnt_q      <= '0;
      bcd_q       <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      pcnt_q      <= pcnt_d;
      bcd_q       <= bcd_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nz;

  // Scan from the top digit down; digit 0 is never blanked so zero still shows.
  always_comb begin
    blank_mask = '0;
    seen_nz    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen_nz       = seen_nz | (bcd_q[4*i +: 4] != 4'd0);
      blank_mask[i] = !seen_nz;
    end
  end
`else
  assign blank_mask = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_seg7 u_seg7 (
      .nibble (bcd_q[4*g +: 4]),
      .blank  (blank_mask[g]),
      .seg    (hex[7*g +: 7])
    );
  end

  assign bcd       = bcd_q;
  assign carry     = carry_q;
  assign err       = err_q;
  assign err_digit = err_digit_q;

endmodule

// File: tb/tb_bcd_counter_hex.sv
// tb/tb_bcd_counter_hex.sv - self-checking bench: vector table, directed corners, randomized model check
module tb_bcd_counter_hex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: DIGITS=2, PRESCALE=1
  logic        a_rstn, a_en, a_up, a_load, a_clr;
  logic [7:0]  a_lv, a_bcd;
  logic [13:0] a_hex;
  logic        a_carry, a_err;
  logic [1:0]  a_ed;

  // DUT b: DIGITS=3, PRESCALE=4
  logic        b_rstn, b_en, b_up, b_load, b_clr;
  logic [11:0] b_lv, b_bcd;
  logic [20:0] b_hex;
  logic        b_carry, b_err;
  logic [2:0]  b_ed;

  bcd_counter_hex #(.DIGITS(2), .PRESCALE(1)) u_dut_a (
    .CLOCK_50(clk), .RESET_N(a_rstn), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_lv), .clr_err(a_clr), .bcd(a_bcd), .hex(a_hex),
    .carry(a_carry), .err(a_err), .err_digit(a_ed)
  );

  bcd_counter_hex #(.DIGITS(3), .PRESCALE(4)) u_dut_b (
    .CLOCK_50(clk), .RESET_N(b_rstn), .en(b_en), .up(b_up), .load(b_load),
    .load_val(b_lv), .clr_err(b_clr), .bcd(b_bcd), .hex(b_hex),
    .carry(b_carry), .err(b_err), .err_digit(b_ed)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int       v;
    int       p;
    bit       carry;
    bit       err;
    bit [7:0] mask;
  } mstate_t;

  typedef struct {
    bit       rstn, en, up, load, clr;
    bit [7:0] lv;
    bit [7:0] e_bcd;
    bit       e_carry, e_err;
    bit [1:0] e_mask;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [31:0] to_bcd(input int v, input int digits);
    bit [31:0] r = '0;
    for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic int from_bcd(input bit [31:0] b, input int digits);
    int r = 0;
    for (int i = 0; i < digits; i++) r += int'(b[4*i +: 4]) * (10 ** i);
    return r;
  endfunction

  function automatic bit [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit [55:0] exp_hex(input int v, input int digits);
    bit [55:0] r = '0;
    bit [6:0]  s;
    for (int i = 0; i < digits; i++) begin
      s = seg_of((v / (10 ** i)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < 10 ** i) s = 7'b1111111;
`endif
      r[7*i +: 7] = s;
    end
    return r;
  endfunction

  // Counter kept as a plain integer value; BCD and segment views are derived from it.
  function automatic mstate_t model_next(input mstate_t s, input bit rstn, input bit en,
                                         input bit up, input bit load, input bit clr,
                                         input bit [31:0] lv, input int digits, input int ps);
    mstate_t  n = s;
    int       lim = 10 ** digits;
    bit [7:0] bad = '0;
    int       lvv = 0;
    bit       tick;
    if (!rstn) begin
      n.v = 0; n.p = 0; n.carry = 0; n.err = 0; n.mask = '0;
      return n;
    end
    tick    = (s.p == ps - 1);
    n.p     = tick ? 0 : s.p + 1;
    n.carry = 0;
    for (int i = 0; i < digits; i++) begin
      if (lv[4*i +: 4] > 9) bad[i] = 1'b1;
      lvv += int'(lv[4*i +: 4]) * (10 ** i);
    end
    if (load && bad == 0) begin
      n.v = lvv;
      n.p = 0;
    end else if (load) begin
      n.err  = 1;
      n.mask = bad;
    end else if (tick && en) begin
      if (up) begin
        n.v = (s.v + 1) % lim;
        n.carry = (s.v == lim - 1);
      end else begin
        n.v = (s.v == 0) ? lim - 1 : s.v - 1;
        n.carry = (s.v == 0);
      end
    end
    if (clr && !(load && bad != 0)) begin
      n.err  = 0;
      n.mask = '0;
    end
    return n;
  endfunction

  task automatic check_a(input string tag, input mstate_t m);
    chk({tag, ".a.bcd"},   64'(a_bcd),   64'(to_bcd(m.v, 2)));
    chk({tag, ".a.carry"}, 64'(a_carry), 64'(m.carry));
    chk({tag, ".a.err"},   64'(a_err),   64'(m.err));
    chk({tag, ".a.edig"},  64'(a_ed),    64'(m.mask[1:0]));
    chk({tag, ".a.hex"},   64'(a_hex),   64'(exp_hex(m.v, 2)));
  endtask

  task automatic check_b(input string tag, input mstate_t m);
    chk({tag, ".b.bcd"},   64'(b_bcd),   64'(to_bcd(m.v, 3)));
    chk({tag, ".b.carry"}, 64'(b_carry), 64'(m.carry));
    chk({tag, ".b.err"},   64'(b_err),   64'(m.err));
    chk({tag, ".b.edig"},  64'(b_ed),    64'(m.mask[2:0]));
    chk({tag, ".b.hex"},   64'(b_hex),   64'(exp_hex(m.v, 3)));
  endtask

  function automatic bit [31:0] rand_lv(input int digits);
    bit [31:0] r = '0;
    bit        valid = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < digits; i++)
      r[4*i +: 4] = valid ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
    return r;
  endfunction

  vec_t    tbl[17];
  mstate_t ma, mb;
  int      ncarry;
  bit [31:0] rlv;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit [20:0] HEX_007 = {7'b1111111, 7'b1111111, 7'b1111000};
  localparam bit [20:0] HEX_000 = {7'b1111111, 7'b1111111, 7'b1000000};
`else
  localparam bit [20:0] HEX_007 = {7'b1000000, 7'b1000000, 7'b1111000};
  localparam bit [20:0] HEX_000 = {7'b1000000, 7'b1000000, 7'b1000000};
`endif

  initial begin
    a_rstn = 0; a_en = 0; a_up = 1; a_load = 0; a_clr = 0; a_lv = '0;
    b_rstn = 0; b_en = 0; b_up = 1; b_load = 0; b_clr = 0; b_lv = '0;

    // rstn en up load clr lv -> bcd carry err mask
    tbl[0]  = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 2'b00};
    tbl[1]  = '{1, 0, 1, 1, 0, 8'h10, 8'h10, 0, 0, 2'b00};
    tbl[2]  = '{1, 1, 0, 0, 0, 8'h00, 8'h09, 0, 0, 2'b00};
    tbl[3]  = '{1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 2'b00};
    tbl[4]  = '{1, 1, 0, 0, 0, 8'h00, 8'h99, 1, 0, 2'b00};
    tbl[5]  = '{1, 0, 0, 0, 0, 8'h00, 8'h99, 0, 0, 2'b00};
    tbl[6]  = '{1, 1, 1, 1, 0, 8'h3C, 8'h99, 0, 1, 2'b01};
    tbl[7]  = '{1, 0, 1, 0, 1, 8'h00, 8'h99, 0, 0, 2'b00};
    tbl[8]  = '{1, 0, 1, 1, 1, 8'hAB, 8'h99, 0, 1, 2'b11};
    tbl[9]  = '{1, 0, 1, 1, 1, 8'h57, 8'h57, 0, 0, 2'b00};
    tbl[10] = '{1, 1, 1, 1, 0, 8'hA5, 8'h57, 0, 1, 2'b10};
    tbl[11] = '{0, 1, 1, 1, 0, 8'hC3, 8'h00, 0, 0, 2'b00};
    tbl[12] = '{1, 1, 1, 1, 0, 8'h98, 8'h98, 0, 0, 2'b00};
    tbl[13] = '{1, 1, 1, 1, 0, 8'h98, 8'h98, 0, 0, 2'b00};
    tbl[14] = '{1, 1, 1, 0, 0, 8'h00, 8'h99, 0, 0, 2'b00};
    tbl[15] = '{1, 1, 1, 0, 0, 8'h00, 8'h00, 1, 0, 2'b00};
    tbl[16] = '{1, 1, 1, 0, 0, 8'h00, 8'h01, 0, 0, 2'b00};

    // Reset then free-run upward for 100 ticks: 00..99..00 with one carry.
    step();
    chk("rst.bcd",   64'(a_bcd),   64'h0);
    chk("rst.carry", 64'(a_carry), 64'h0);
    chk("rst.err",   64'(a_err),   64'h0);
    chk("rst.edig",  64'(a_ed),    64'h0);
    chk("rst.hex",   64'(a_hex),   64'(exp_hex(0, 2)));
    chk("rst.b.hex", 64'(b_hex),   64'(HEX_000));
    a_rstn = 1; a_en = 1; a_up = 1;
    ncarry = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      chk($sformatf("run%0d.bcd", k),   64'(a_bcd),   64'(to_bcd(k % 100, 2)));
      chk($sformatf("run%0d.carry", k), 64'(a_carry), 64'(k == 100));
      if (a_carry) ncarry++;
    end
    chk("run.ncarry", 64'(ncarry), 64'd1);
    chk("run.dig0",   64'(a_hex[6:0]), 64'(7'b1000000));

    for (int i = 0; i < 17; i++) begin
      a_rstn = tbl[i].rstn; a_en = tbl[i].en; a_up = tbl[i].up;
      a_load = tbl[i].load; a_clr = tbl[i].clr; a_lv = tbl[i].lv;
      step();
      chk($sformatf("vec%0d.bcd", i),   64'(a_bcd),   64'(tbl[i].e_bcd));
      chk($sformatf("vec%0d.carry", i), 64'(a_carry), 64'(tbl[i].e_carry));
      chk($sformatf("vec%0d.err", i),   64'(a_err),   64'(tbl[i].e_err));
      chk($sformatf("vec%0d.edig", i),  64'(a_ed),    64'(tbl[i].e_mask));
      chk($sformatf("vec%0d.hex", i),   64'(a_hex),
          64'(exp_hex(from_bcd(32'(tbl[i].e_bcd), 2), 2)));
    end

    // Load collides with the tick cycle (pcnt==3); next tick is 4 cycles later.
    b_rstn = 0; b_en = 0;
    step();
    b_rstn = 1; b_en = 1; b_up = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("pre%0d.bcd", k), 64'(b_bcd), 64'h000);
    end
    b_load = 1; b_lv = 12'h042;
    step();
    chk("coll.bcd", 64'(b_bcd), 64'h042);
    b_load = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("coll%0d.hold", k), 64'(b_bcd), 64'h042);
    end
    step();
    chk("coll.tick", 64'(b_bcd), 64'h043);

    b_en = 0; b_load = 1; b_lv = 12'h007;
    step();
    chk("blank7.hex", 64'(b_hex), 64'(HEX_007));
    b_lv = 12'h000;
    step();
    chk("blank0.hex",  64'(b_hex), 64'(HEX_000));
    chk("blank0.dig0", 64'(b_hex[6:0]), 64'(7'b1000000));
    b_load = 0;

    // Randomized run of both instances against the integer model.
    a_rstn = 0; b_rstn = 0; a_load = 0; b_load = 0; a_clr = 0; b_clr = 0;
    ma = model_next(ma, 0, 0, 0, 0, 0, 0, 2, 1);
    mb = model_next(mb, 0, 0, 0, 0, 0, 0, 3, 4);
    step();
    check_a("rnd.init", ma);
    check_b("rnd.init", mb);
    for (int k = 0; k < 800; k++) begin
      a_rstn = ($urandom_range(0, 63) != 0);
      a_en   = ($urandom_range(0, 3) != 0);
      a_up   = ($urandom_range(0, 7) != 0) ? a_up : ~a_up;
      a_load = ($urandom_range(0, 15) == 0);
      a_clr  = ($urandom_range(0, 15) == 0);
      rlv    = rand_lv(2);
      a_lv   = rlv[7:0];
      b_rstn = ($urandom_range(0, 63) != 0);
      b_en   = ($urandom_range(0, 3) != 0);
      b_up   = ($urandom_range(0, 7) != 0) ? b_up : ~b_up;
      b_load = ($urandom_range(0, 15) == 0);
      b_clr  = ($urandom_range(0, 15) == 0);
      rlv    = rand_lv(3);
      b_lv   = rlv[11:0];
      ma = model_next(ma, a_rstn, a_en, a_up, a_load, a_clr, 32'(a_lv), 2, 1);
      mb = model_next(mb, b_rstn, b_en, b_up, b_load, b_clr, 32'(b_lv), 3, 4);
      step();
      check_a($sformatf("rnd%0d", k), ma);
      check_b($sformatf("rnd%0d", k), mb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_counter_hex.md
# bcd_counter_hex

Parametrised multi-digit BCD up/down counter with per-digit active-low 7-segment outputs. It replaces the fixed two-digit combinational BCD display decode in the board top level with a clocked counter. The counter has a programmable tick prescaler, a validated parallel load from switches, wrap/carry signalling and a sticky invalid-load error. It sits between the board I/O (SW/KEY) and the HEX/LEDR pins.

## Interface
- `DIGITS`, default 2: number of BCD digits (1..8).
- `PRESCALE`, default 50_000_000: clock cycles per count tick (≥1).
- `CLOCK_50` in, 1: system clock; all state changes on rising edge.
- `RESET_N` in, 1: reset, synchronous, active-low.
- `en` in, 1: count enable, sampled on tick.
- `up` in, 1: direction; 1 = increment, 0 = decrement.
- `load` in, 1: load request, level-sampled each cycle.
- `load_val` in, 4*DIGITS: BCD load value; nibble i is digit i, digit 0 least significant.
- `clr_err` in, 1: clears `err` and `err_digit`.
- `bcd` out, 4*DIGITS: current count.
- `hex` out, 7*DIGITS: segments; digit i is bits [7i+6:7i], bit 7i+0 = a … 7i+6 = g, 0 = lit.
- `carry` out, 1: one-cycle pulse on wrap.
- `err` out, 1: sticky, set by a rejected load.
- `err_digit` out, DIGITS: bit i set if nibble i of the last rejected load was >9.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. `tick` is asserted in the cycle `pcnt == PRESCALE-1`. When PRESCALE=1, `tick` is asserted every cycle.
- Priority each cycle: reset > load > tick. `clr_err` is handled independently of the count path.
- Load, valid (all nibbles ≤9): `bcd` <= `load_val`, and `pcnt` <= 0. A tick in that same cycle is discarded. `err` is unchanged.
- Load, invalid (any nibble >9): `bcd` is unchanged and `pcnt` keeps running. `err` <= 1, and `err_digit` <= mask of the offending nibbles.
- Tick with en=1, up=1: ripple BCD increment. A digit at 9 becomes 0 and carries into the next digit. All-9s becomes all-0s and `carry` pulses.
- Tick with en=1, up=0: ripple BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. All-0s becomes all-9s and `carry` pulses.
- Tick with en=0: `bcd` holds. The prescaler still runs.
- `clr_err` clears `err` and `err_digit`. If an invalid load occurs in the same cycle, set wins and the new mask is loaded.
- `bcd` never holds a nibble >9.
- Segment patterns (g..a, active-low) are fixed as follows:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - blank = 1111111

## Timing
- Reset values: `bcd` = 0, `pcnt` = 0, `carry` = 0, `err` = 0, `err_digit` = 0. `hex` shows "0" on every digit, or only on digit 0 when LEADING_ZERO_BLANK_EN is defined.
- `bcd`, `carry`, `err` and `err_digit` are registered.
- Load latency: `bcd` shows the loaded value 1 cycle after `load` is sampled high.
- Count latency: `bcd` updates on the edge ending the tick cycle. `carry` is high in exactly that following cycle only.
- `hex` is combinational from `bcd` and gives zero extra latency.
- Holding `load` high reloads every cycle and suppresses counting.
- Reset asserted mid-count takes effect on the next edge and overrides load and tick.

## Configuration
- `LEADING_ZERO_BLANK_EN`, defined:
  - Digits above the most significant non-zero digit are driven blank.
  - Digit 0 is always displayed, so 0 shows as a single "0".
  - `bcd` is unaffected.
- Not defined: all digits are always displayed, including leading zeros.

## Structure
- Package `bcd_pkg` holds:
  - the ten segment pattern constants;
  - `SEG_BLANK`;
  - the `seg7_t` typedef (7-bit);
  - the function `bcd_valid(nibble)`.
- Sub-module `bcd_seg7` is a combinational nibble-to-`seg7_t` decoder with a `blank` input. Inputs >9 display blank.
- The top level instantiates `bcd_seg7` DIGITS times in a generate loop.

## Test plan
- Reset and basic count:
  - Stimulus: DIGITS=2, PRESCALE=1, reset, then en=1, up=1 for 100 cycles.
  - Expected: `bcd` runs 00→99→00, with a single `carry` pulse at the 99→00 edge.
  - Expected: `hex` digit0 = 1000000 after the wrap.
- Decrement borrow:
  - Stimulus: load 0x10, then up=0 with one tick.
  - Expected: `bcd` = 0x09.
  - Stimulus: load 0x00, then one tick.
  - Expected: `bcd` = 0x99 and `carry` = 1 for one cycle.
- Invalid load:
  - Stimulus: load 0x3C.
  - Expected: `bcd` unchanged, `err` = 1, `err_digit` = 2'b01.
  - Stimulus: assert `clr_err` for one cycle.
  - Expected: `err` = 0 and `err_digit` = 0.
- Load vs tick collision:
  - Stimulus: PRESCALE=4; assert load 0x42 in the cycle where `pcnt` = 3.
  - Expected: `bcd` = 0x42.
  - Expected: the next tick comes 4 cycles later and gives `bcd` = 0x43.
- Reset mid-operation:
  - Stimulus: assert RESET_N=0 for one cycle while `bcd` = 0x57, en=1, a tick is pending and an invalid load is applied.
  - Expected: `bcd` = 0, `err` = 0, `carry` = 0 on the next cycle.
- Leading-zero blanking:
  - Stimulus: LEADING_ZERO_BLANK_EN defined, DIGITS=3, load 0x007.
  - Expected: digits 2 and 1 are 1111111 and digit 0 is 1111000.
  - Stimulus: load 0x000.
  - Expected: digit 0 is 1000000.
